// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per
// clock, with the carry rippled through a flop between cycles.
// Subtraction is A + ~B + ~cin; the carry-out is inverted back into a borrow.
// WIDTH must be a multiple of CHUNK.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry, a_msb, b_msb, sub_r;
    logic             accept, last;
    logic [WIDTH-1:0] b_eff;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] sum_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == ADD) && (cnt == LAST);
    assign b_eff     = sub ? ~b : b;
    assign sum       = sum_sh;

    // One chunk of the ripple: low CHUNK bits of each operand plus the carry
    // flop; the result chunk enters the sum register from the top so the
    // LSB chunk ends up at the bottom after NCHUNK shifts.
    always_comb begin
        chunk_res = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                  + (CHUNK+1)'(carry);
        sum_nxt   = (sum_sh >> CHUNK)
                  | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> ADD on accept, ADD -> DONE after the last
    // chunk, DONE -> IDLE once the consumer takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADD;
            ADD:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-chunk shift/add, and result flags
    // latched on the final chunk so they hold through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sub_r  <= 1'b0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            sub_r <= sub;
        end else if (state == ADD) begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            sum_sh <= sum_nxt;
            carry  <= chunk_res[CHUNK];
            cnt    <= cnt + 1'b1;
            if (last) begin
                cout <= chunk_res[CHUNK] ^ sub_r;
                ovf  <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: directed cases on the 8/2 configuration,
// plus a random sweep run in lock-step across 8/2, 8/1, 8/4, 8/8 and 16/4.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [4:0]  irdy, ov, co, of;
    logic [7:0]  s0, s1, s2, s3;
    logic [15:0] s4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(ov[0]),
        .out_ready(out_ready), .sum(s0), .cout(co[0]), .ovf(of[0]));
    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(ov[1]),
        .out_ready(out_ready), .sum(s1), .cout(co[1]), .ovf(of[1]));
    chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(ov[2]),
        .out_ready(out_ready), .sum(s2), .cout(co[2]), .ovf(of[2]));
    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[3]),
        .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(ov[3]),
        .out_ready(out_ready), .sum(s3), .cout(co[3]), .ovf(of[3]));
    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[4]),
        .a(a16), .b(b16), .cin(cin), .sub(sub), .out_valid(ov[4]),
        .out_ready(out_ready), .sum(s4), .cout(co[4]), .ovf(of[4]));

    function automatic int wid(int i);
        return (i == 4) ? 16 : 8;
    endfunction

    function automatic int nch(int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 2;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] sum_of(int i);
        case (i)
            0: return {8'h00, s0};
            1: return {8'h00, s1};
            2: return {8'h00, s2};
            3: return {8'h00, s3};
            default: return s4;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    // Returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_res(int w, logic [15:0] ra, logic [15:0] rb,
                                            logic rc, logic rs);
        longint m, half, ua, ub, c, r, sa, sb, sr;
        logic   cy, ov_b;
        logic [15:0] s;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(ra) & m;
        ub   = longint'(rb) & m;
        c    = rc ? 1 : 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (rs) begin
            r  = ua - ub - c;
            cy = (r < 0);
            sr = sa - sb - c;
        end else begin
            r  = ua + ub + c;
            cy = (r > m);
            sr = sa + sb + c;
        end
        ov_b = (sr < -half) || (sr >= half);
        s    = 16'(r & m);
        return {ov_b, cy, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release every instance's result and wait until all are idle again.
    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (irdy != 5'h1f && k < 40) begin
            step();
            k++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (irdy !== 5'h1f) begin
            $display("FAIL drain: in_ready=%b required 11111", irdy);
            n_err++;
        end
    endtask

    // One directed op on the 8/2 instance with exact latency check.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input logic ts, input logic [7:0] es, input logic ec,
                         input logic eo, input string name);
        int lat;
        a8 = ta; b8 = tb_; a16 = {8'h00, ta}; b16 = {8'h00, tb_};
        cin = tc; sub = ts;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin
            $display("FAIL %s latency: got %0d required 4", name, lat);
            n_err++;
        end
        n_cmp++;
        if ({s0, co[0], of[0]} !== {es, ec, eo}) begin
            $display("FAIL %s result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     name, s0, co[0], of[0], es, ec, eo);
            n_err++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if ({irdy[0], ov[0]} !== 2'b10) begin
            $display("FAIL %s release: in_ready=%b out_valid=%b required 1 0",
                     name, irdy[0], ov[0]);
            n_err++;
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({irdy[0], ov[0], s0, co[0], of[0], s4} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0}) begin
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b sum16=%h required 1 0 00 0 0 0000",
                     irdy[0], ov[0], s0, co[0], of[0], s4);
            n_err++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "add_ff_01_c");
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, "sub_10_20");
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        do_op(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_05_05_b");
    endtask

    task automatic test_backpressure();
        int lat;
        a8 = 8'h5A; b8 = 8'h3C; a16 = 16'h005A; b16 = 16'h003C;
        cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 20) begin
            step();
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a8 = 8'h11; b8 = 8'h22; in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            n_cmp++;
            if ({ov[0], irdy[0], s0, co[0], of[0]} !== {1'b1, 1'b0, 8'h96, 1'b0, 1'b1}) begin
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 96 0 1",
                         k, ov[0], irdy[0], s0, co[0], of[0]);
                n_err++;
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if ({irdy[0], ov[0]} !== 2'b10) begin
            $display("FAIL backpressure release: in_ready=%b out_valid=%b required 1 0", irdy[0], ov[0]);
            n_err++;
        end
        step();
        step();
        n_cmp++;
        if ({ov[0], s0} !== {1'b0, 8'h96}) begin
            $display("FAIL backpressure ignored pulse: out_valid=%b sum=%h required 0 96", ov[0], s0);
            n_err++;
        end
        drain();
    endtask

    task automatic test_reset_mid_add();
        a8 = 8'h5A; b8 = 8'h3C; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ov[0], irdy[0], s0, co[0], of[0]} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_mid_add: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 0 1 00 0 0",
                     ov[0], irdy[0], s0, co[0], of[0]);
            n_err++;
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_cmp++;
        if (ov !== 5'h00) begin
            $display("FAIL reset_stale_valid: out_valid=%b required 00000", ov);
            n_err++;
        end
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset_add");
    endtask

    task automatic test_sweep();
        logic [31:0] ra, rb;
        logic [17:0] exp_r, got;
        logic [4:0]  seen;
        int cyc;
        for (int it = 0; it < 1000; it++) begin
            ra = $urandom; rb = $urandom;
            a16 = ra[15:0]; b16 = rb[15:0];
            a8 = ra[7:0];   b8 = rb[7:0];
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            seen = '0;
            cyc = 0;
            while (seen != 5'h1f && cyc < 40) begin
                step();
                cyc++;
                for (int i = 0; i < 5; i++) begin
                    if (!seen[i] && ov[i]) begin
                        seen[i] = 1'b1;
                        exp_r = ref_res(wid(i), a16, b16, cin, sub);
                        got   = {of[i], co[i], sum_of(i)};
                        n_cmp++;
                        if (cyc != nch(i) || got !== exp_r) begin
                            $display("FAIL sweep op %0d inst %0d (W=%0d): lat=%0d {ovf,cout,sum}=%h required lat=%0d %h",
                                     it, i, wid(i), cyc, got, nch(i), exp_r);
                            n_err++;
                        end
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (!seen[i]) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sweep op %0d inst %0d timeout: out_valid never rose", it, i);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_add();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised successor to the combinational full adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between cycles.
- Trades latency for area; used where a wide adder must not close timing in one cycle.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; 1 gives a pure bit-serial adder, CHUNK=WIDTH gives a 1-cycle adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) or borrow-out (sub).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Internal operand and carry registers are cleared.
- NCHUNK = WIDTH/CHUNK. Chunk counter width = clog2(NCHUNK), minimum 1.
- FSM IDLE -> ADD -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T, capture a, b_eff and c_eff, clear the counter, go to ADD.
  - b_eff = sub ? ~b : b. c_eff = sub ? ~cin : cin.
  - Also latch a[WIDTH-1] and b_eff[WIDTH-1] for overflow.
- ADD:
  - in_ready=0.
  - Each cycle: add the low CHUNK bits of the A and B shift registers plus the carry flop (CHUNK+1-bit result).
  - The low CHUNK bits shift into the top of the sum register (LSB chunk first). The MSB goes to the carry flop.
  - Both operand registers shift right by CHUNK.
  - After the NCHUNK-th ADD cycle (edge T+NCHUNK), go to DONE.
- DONE:
  - out_valid=1.
  - cout = sub ? ~carry : carry.
  - ovf = (a_msb == b_eff_msb) && (sum[WIDTH-1] != a_msb).
  - sum/cout/ovf hold stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, go to IDLE: out_valid=0, in_ready=1 from the next cycle. sum/cout/ovf keep their last values.
- Latency: first out_valid cycle is NCHUNK cycles after the input handshake edge. Minimum op-to-op period is NCHUNK+2 cycles.
- in_valid while in_ready=0 is ignored; inputs need not be held after acceptance.
- Input changes during ADD/DONE have no effect on the result.
- Arithmetic is modulo 2^WIDTH; sum is never widened.
- Carry/borrow out is only via cout.
- Reset asserted mid-ADD or mid-DONE aborts the operation immediately: all outputs return to reset values and no stale out_valid is produced after release.
- CHUNK=WIDTH: single ADD cycle, latency 1, same protocol.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- Add 0x5A+0x3C, cin=0, sub=0 -> exactly 4 cycles after accept: out_valid=1, sum=0x96, cout=0, ovf=1.
- Add 0xFF+0x01, cin=1 -> sum=0x01, cout=1, ovf=0. Subtract 0x10-0x20, cin=0 -> sum=0xF0, cout(borrow)=1, ovf=0.
- Subtract 0x80-0x01 -> sum=0x7F, cout=0, ovf=1. Subtract 0x05-0x05 with cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout/ovf constant, in_ready=0, and a second in_valid pulse is not accepted. out_ready=1 -> in_ready=1 the next cycle.
- Reset: assert rst_n=0 two cycles into ADD -> out_valid=0, sum=0, in_ready=1 immediately. After release, an add of 0x01+0x01 -> sum=0x02 with 4-cycle latency.
- Parameter sweep: CHUNK=1, 4, 8 with WIDTH=8, and WIDTH=16/CHUNK=4, with 1000 random ops against a reference model -> all results match; latency equals WIDTH/CHUNK every time.
